switch_allocator: RTL and testbench

- Per-router switch control for the Phoenix XY mesh.
- Picks one pending header among the NPORT input buffers using round-robin order.
- Computes the XY output port for that header's destination field.
- If that output is free, grants it and drives the crossbar select tables. Holds the connection until the owning input stops sending.

---
 rtl/switch_allocator_pkg.sv | 39 +++
 rtl/switch_allocator_rr_picker.sv | 26 ++
 rtl/switch_allocator.sv | 94 +++++++++
 tb/tb_switch_allocator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
// rtl/switch_allocator_pkg.sv - shared constants, FSM encoding and XY routing helper
package switch_allocator_pkg;

    localparam int NPORT      = 5;
    localparam int TAM_FLIT   = 16;
    localparam int METADEFLIT = 8;
    localparam int PORT_BITS  = 3;

    localparam logic [PORT_BITS-1:0] EAST  = 3'd0;
    localparam logic [PORT_BITS-1:0] WEST  = 3'd1;
    localparam logic [PORT_BITS-1:0] NORTH = 3'd2;
    localparam logic [PORT_BITS-1:0] SOUTH = 3'd3;
    localparam logic [PORT_BITS-1:0] LOCAL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ROUTE = 2'd2,
        S_GRANT = 2'd3
    } state_t;

    // X is resolved before Y; all compares are unsigned.
    function automatic logic [PORT_BITS-1:0] xy_route(
        input logic [TAM_FLIT-1:0] dest,
        input logic [TAM_FLIT-1:0] addr
    );
        logic [METADEFLIT-1:0] dest_x, dest_y, local_x, local_y;
        dest_x  = dest[TAM_FLIT-1 -: METADEFLIT];
        dest_y  = dest[METADEFLIT-1:0];
        local_x = addr[TAM_FLIT-1 -: METADEFLIT];
        local_y = addr[METADEFLIT-1:0];
        if (dest_x > local_x)      return EAST;
        else if (dest_x < local_x) return WEST;
        else if (dest_y < local_y) return SOUTH;
        else if (dest_y > local_y) return NORTH;
        else                       return LOCAL;
    endfunction

endpackage

// File: rtl/switch_allocator_rr_picker.sv
// rtl/switch_allocator_rr_picker.sv - combinational round-robin request picker
module switch_allocator_rr_picker
    import switch_allocator_pkg::*;
(
    input  logic [NPORT-1:0]     req,
    input  logic [PORT_BITS-1:0] ptr,
    output logic [PORT_BITS-1:0] sel,
    output logic                 valid
);

    // Search starts one past ptr so the last winner has lowest priority.
    always_comb begin : pick
        logic [PORT_BITS-1:0] idx;
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = PORT_BITS'((int'(ptr) + k) % NPORT);
            if (!valid && req[idx]) begin
                sel   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - XY-mesh router switch allocator with round-robin arbitration
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter logic [TAM_FLIT-1:0] ADDRESS = 16'h0000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NPORT-1:0]             h,
    input  logic [NPORT*TAM_FLIT-1:0]    data_in,
    input  logic [NPORT-1:0]             sender,
    output logic [NPORT-1:0]             ack_h,
    output logic [NPORT-1:0]             free,
    output logic [NPORT*PORT_BITS-1:0]   mux_in,
    output logic [NPORT*PORT_BITS-1:0]   mux_out
);

    state_t               state, state_nxt;
    logic [PORT_BITS-1:0] rr_ptr, sel, tgt, pick, route;
    logic                 pick_valid;
    logic [NPORT-1:0]     just_granted, release_v;
    logic [TAM_FLIT-1:0]  dest;

    switch_allocator_rr_picker u_picker (
        .req   (h),
        .ptr   (rr_ptr),
        .sel   (pick),
        .valid (pick_valid)
    );

    assign dest  = data_in[sel*TAM_FLIT +: TAM_FLIT];
    assign route = xy_route(dest, ADDRESS);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|h) state_nxt = S_ARB;
            S_ARB:   state_nxt = pick_valid ? S_ROUTE : S_IDLE;
            S_ROUTE: state_nxt = free[route] ? S_GRANT : S_IDLE;
            S_GRANT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // just_granted masks the release for one cycle so the input can raise sender.
    always_comb begin
        release_v = '0;
        for (int o = 0; o < NPORT; o++) begin
            release_v[o] = !free[o] && !sender[mux_in[o*PORT_BITS +: PORT_BITS]]
                           && !just_granted[o];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= LOCAL;
            sel          <= '0;
            tgt          <= '0;
            ack_h        <= '0;
            free         <= '1;
            mux_in       <= '0;
            mux_out      <= '0;
            just_granted <= '0;
        end else begin
            state        <= state_nxt;
            ack_h        <= '0;
            just_granted <= '0;
            for (int o = 0; o < NPORT; o++) begin
                if (release_v[o]) free[o] <= 1'b1;
            end
            case (state)
                S_ARB: begin
                    if (pick_valid) sel <= pick;
                end
                S_ROUTE: begin
                    tgt <= route;
                    // A blocked requester gives up its turn to avoid starving others.
                    if (!free[route]) rr_ptr <= sel;
                end
                S_GRANT: begin
                    ack_h[sel]                             <= 1'b1;
                    free[tgt]                              <= 1'b0;
                    mux_in[tgt*PORT_BITS +: PORT_BITS]     <= sel;
                    mux_out[sel*PORT_BITS +: PORT_BITS]    <= tgt;
                    rr_ptr                                 <= sel;
                    just_granted[tgt]                      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed self-checking bench for switch_allocator
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [NPORT-1:0]           h;
    logic [NPORT*TAM_FLIT-1:0]  data_in;
    logic [NPORT-1:0]           sender;
    logic [NPORT-1:0]           ack_h;
    logic [NPORT-1:0]           free;
    logic [NPORT*PORT_BITS-1:0] mux_in;
    logic [NPORT*PORT_BITS-1:0] mux_out;

    int checks = 0;
    int errors = 0;

    switch_allocator #(.ADDRESS(16'h0101)) dut (
        .clock   (clock),
        .reset   (reset),
        .h       (h),
        .data_in (data_in),
        .sender  (sender),
        .ack_h   (ack_h),
        .free    (free),
        .mux_in  (mux_in),
        .mux_out (mux_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [PORT_BITS-1:0] mux_in_of(input int o);
        return mux_in[o*PORT_BITS +: PORT_BITS];
    endfunction

    function automatic logic [PORT_BITS-1:0] mux_out_of(input int i);
        return mux_out[i*PORT_BITS +: PORT_BITS];
    endfunction

    task automatic set_dest(input int port, input logic [TAM_FLIT-1:0] d);
        data_in[port*TAM_FLIT +: TAM_FLIT] = d;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Single requester: grant after 4 edges, then grace cycle, then release.
    task automatic do_route(input string tag, input int port, input logic [TAM_FLIT-1:0] d,
                            input int exp_tgt);
        set_dest(port, d);
        h[port] = 1'b1;
        step(); step(); step();
        step();
        check({tag, "_ack"}, 32'(ack_h), 32'(1) << port);
        check({tag, "_mux_out"}, 32'(mux_out_of(port)), 32'(exp_tgt));
        check({tag, "_mux_in"}, 32'(mux_in_of(exp_tgt)), 32'(port));
        check({tag, "_busy"}, 32'(free[exp_tgt]), 32'd0);
        h[port] = 1'b0;
        step();
        check({tag, "_grace"}, 32'(free[exp_tgt]), 32'd0);
        step();
        check({tag, "_released"}, 32'(free[exp_tgt]), 32'd1);
    endtask

    initial begin
        logic [NPORT-1:0] acc;
        reset   = 1'b1;
        h       = '0;
        data_in = '0;
        sender  = '0;
        step(); step();
        check("rst_ack", 32'(ack_h), 32'd0);
        check("rst_free", 32'(free), 32'h1f);
        check("rst_mux_in", 32'(mux_in), 32'd0);
        check("rst_mux_out", 32'(mux_out), 32'd0);
        reset = 1'b0;

        // LOCAL to EAST, then hold with sender for 6 cycles
        set_dest(4, 16'h0201);
        h[4] = 1'b1;
        step(); step(); step();
        check("lat_early", 32'(ack_h), 32'd0);
        step();
        check("lat_ack", 32'(ack_h), 32'b10000);
        check("lat_free_e", 32'(free[EAST]), 32'd0);
        check("lat_mux_in_e", 32'(mux_in_of(0)), 32'd4);
        check("lat_mux_out_l", 32'(mux_out_of(4)), 32'd0);
        h[4]      = 1'b0;
        sender[4] = 1'b1;
        step();
        check("ack_one_cycle", 32'(ack_h), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_busy", 32'(free[EAST]), 32'd0);
        end
        sender[4] = 1'b0;
        check("pre_release", 32'(free[EAST]), 32'd0);
        step();
        check("release", 32'(free[EAST]), 32'd1);

        // XY routing from 0x0101
        do_route("rt_local", 4, 16'h0101, 4);
        do_route("rt_west",  0, 16'h0001, 1);
        do_route("rt_north", 1, 16'h0102, 2);
        do_route("rt_south", 2, 16'h0100, 3);
        do_route("rt_east",  3, 16'h0201, 0);

        // EAST and NORTH both to SOUTH: EAST first, NORTH refused until release
        pulse_reset();
        set_dest(0, 16'h0100);
        set_dest(2, 16'h0100);
        h = 5'b00101;
        step(); step(); step(); step();
        check("cf_first", 32'(ack_h), 32'b00001);
        check("cf_first_mux", 32'(mux_in_of(3)), 32'd0);
        h[0]      = 1'b0;
        sender[0] = 1'b1;
        acc = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            acc |= ack_h;
        end
        check("cf_blocked", 32'(acc), 32'd0);
        check("cf_busy", 32'(free[SOUTH]), 32'd0);
        sender[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ack_h != '0) break;
        end
        check("cf_second", 32'(ack_h), 32'b00100);
        check("cf_second_mux", 32'(mux_in_of(3)), 32'd2);
        h = '0;
        step(); step(); step();

        // Fairness with all five requesting distinct outputs
        pulse_reset();
        set_dest(0, 16'h0201);
        set_dest(1, 16'h0001);
        set_dest(2, 16'h0102);
        set_dest(3, 16'h0100);
        set_dest(4, 16'h0101);
        h = 5'b11111;
        for (int k = 0; k < NPORT; k++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                if (ack_h != '0) break;
            end
            check("fair_order", 32'(ack_h), 32'(1) << k);
        end
        h = '0;
        step(); step(); step();

        // Reset while in S_ROUTE kills the pending grant
        pulse_reset();
        set_dest(4, 16'h0201);
        h[4] = 1'b1;
        step(); step();
        reset = 1'b1;
        h     = '0;
        step();
        check("rst_route_ack", 32'(ack_h), 32'd0);
        check("rst_route_free", 32'(free), 32'h1f);
        reset = 1'b0;
        acc = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            acc |= ack_h;
        end
        check("rst_route_nogrant", 32'(acc), 32'd0);
        check("rst_route_free2", 32'(free), 32'h1f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
